// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and the maximal-length tap-mask table
// for the Fibonacci LFSRs used as delay sources by the memory models.
package lfsr_pkg;

    localparam int unsigned MIN_WIDTH    = 3;
    localparam int unsigned MAX_WIDTH    = 32;
    localparam int unsigned DEFAULT_SEED = 1;

    // Tap mask for a maximal-length LFSR of the given width. Bit n-1 of the
    // mask corresponds to tap n of the classic maximal-length table.
    // An out-of-range width returns zero; the module rejects such widths.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        taps = 32'h0;
        case (width)
            3:  taps = 32'h0000_0006;
            4:  taps = 32'h0000_000C;
            5:  taps = 32'h0000_0014;
            6:  taps = 32'h0000_0030;
            7:  taps = 32'h0000_0060;
            8:  taps = 32'h0000_00B8;
            9:  taps = 32'h0000_0110;
            10: taps = 32'h0000_0240;
            11: taps = 32'h0000_0500;
            12: taps = 32'h0000_0829;
            13: taps = 32'h0000_100D;
            14: taps = 32'h0000_2015;
            15: taps = 32'h0000_6000;
            16: taps = 32'h0000_D008;
            17: taps = 32'h0001_2000;
            18: taps = 32'h0002_0400;
            19: taps = 32'h0004_0023;
            20: taps = 32'h0009_0000;
            21: taps = 32'h0014_0000;
            22: taps = 32'h0030_0000;
            23: taps = 32'h0042_0000;
            24: taps = 32'h00E1_0000;
            25: taps = 32'h0120_0000;
            26: taps = 32'h0200_0023;
            27: taps = 32'h0400_0013;
            28: taps = 32'h0900_0000;
            29: taps = 32'h1400_0000;
            30: taps = 32'h2000_0029;
            31: taps = 32'h4800_0000;
            32: taps = 32'h8020_0003;
            default: taps = 32'h0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/delay_lfsr.sv
// delay_lfsr: free-running Fibonacci LFSR, one step per clock, whose
// registered state is the pseudo-random output.
// Optional build macro LFSR_LOAD_EN adds a synchronous seed-load port
// (load / load_val); without it the block has only clk, rst and dout.
module delay_lfsr
    import lfsr_pkg::*;
#(
    parameter int unsigned           WIDTH = 8,
    parameter logic [WIDTH-1:0]      SEED  = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(lfsr_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
`ifdef LFSR_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] dout
);

    // All-zero is the lock-up state of an XOR LFSR, so any path that could
    // land there is redirected to this value instead.
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_VALUE = (SEED == '0) ? ONE : SEED;

    // Reject unsupported widths while elaborating.
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("delay_lfsr: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] shifted;
    logic             fb;

    // Next-state: shift in the tap parity, escape all-zero, then the
    // optional load overrides the step.
    always_comb begin
        fb         = ^(state & TAPS);
        shifted    = {state[WIDTH-2:0], fb};
        next_state = (state == '0) ? ONE : shifted;
`ifdef LFSR_LOAD_EN
        if (load) begin
            next_state = (load_val == '0) ? ONE : load_val;
        end
`endif
    end

    // State register: synchronous reset takes priority over load and step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_VALUE;
        end else begin
            state <= next_state;
        end
    end

    assign dout = state;

endmodule

// File: tb/tb_delay_lfsr.sv
// tb_delay_lfsr: directed checks of delay_lfsr at WIDTH=8, with a default
// instance (SEED=1) and a SEED=0 instance. The load checks are built when
// LFSR_LOAD_EN is defined.
module tb_delay_lfsr;

    logic       clk;
    logic       rst;
    logic [7:0] dout_a;
    logic [7:0] dout_b;
`ifdef LFSR_LOAD_EN
    logic       load;
    logic [7:0] load_val;
    logic       load_b;
    logic [7:0] load_val_b;
`endif

    int passed;
    int total;

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    delay_lfsr #(.WIDTH(8)) dut_a (
        .clk      (clk),
        .rst      (rst),
`ifdef LFSR_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .dout     (dout_a)
    );

    delay_lfsr #(.WIDTH(8), .SEED(8'h00)) dut_b (
        .clk      (clk),
        .rst      (rst),
`ifdef LFSR_LOAD_EN
        .load     (load_b),
        .load_val (load_val_b),
`endif
        .dout     (dout_b)
    );

    // Reference step from the polynomial x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] model_next(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_seq [8];
        int         hits [256];
        int         distinct;
        int         zero_hits;
        logic [7:0] model;

        passed = 0;
        total  = 0;
        exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
`ifdef LFSR_LOAD_EN
        load       = 1'b0;
        load_val   = 8'h00;
        load_b     = 1'b0;
        load_val_b = 8'h00;
`endif

        // Reset value for both SEED=1 and SEED=0 (replaced by 1).
        rst = 1'b1;
        step();
        check("reset_seed1", dout_a, 8'h01);
        step();
        check("reset_held", dout_a, 8'h01);
        check("reset_seed0", dout_b, 8'h01);

        // First steps after reset, hand-computed sequence.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("seq_a_%0d", i), dout_a, exp_seq[i]);
            check($sformatf("seq_b_%0d", i), dout_b, exp_seq[i]);
        end

        // Full period: 255 steps from reset visit 01..FF once each.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int v = 0; v < 256; v++) hits[v] = 0;
        model = 8'h01;
        for (int s = 1; s <= 255; s++) begin
            step();
            model = model_next(model);
            check($sformatf("period_step_%0d", s), dout_a, model);
            if (!$isunknown(dout_a)) hits[dout_a]++;
        end
        distinct  = 0;
        for (int v = 1; v < 256; v++) if (hits[v] == 1) distinct++;
        zero_hits = hits[0];
        check("period_distinct", 8'(distinct), 8'd255);
        check("period_zero_seen", 8'(zero_hits), 8'd0);
        check("period_wrap", dout_a, 8'h01);

        // Reset mid-run at state 47, then the sequence restarts.
        for (int i = 0; i < 6; i++) step();
        check("midrun_before", dout_a, 8'h47);
        rst = 1'b1;
        step();
        check("midrun_reset", dout_a, 8'h01);
        check("midrun_reset_b", dout_b, 8'h01);
        rst = 1'b0;
        step();
        check("midrun_resume_0", dout_a, 8'h02);
        step();
        check("midrun_resume_1", dout_a, 8'h04);

`ifdef LFSR_LOAD_EN
        // Load overrides the step; zero load becomes 1.
        load     = 1'b1;
        load_val = 8'h8E;
        step();
        check("load_8e", dout_a, 8'h8E);
        check("load_b_idle", dout_b, 8'h08);
        load     = 1'b0;
        step();
        check("load_then_step", dout_a, 8'h1C);
        load     = 1'b1;
        load_val = 8'h00;
        step();
        check("load_zero", dout_a, 8'h01);
        load     = 1'b0;
        step();
        check("load_zero_step", dout_a, 8'h02);

        // Reset beats a simultaneous load.
        rst      = 1'b1;
        load     = 1'b1;
        load_val = 8'h55;
        step();
        check("rst_beats_load", dout_a, 8'h01);
        rst      = 1'b0;
        load     = 1'b0;
        step();
        check("after_rst_load", dout_a, 8'h02);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
